// File: rtl/instr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : instr_sequencer                                              |
// | Description : 16x12 instruction store that streams a program into the     |
// |               processor, holding each instruction for a class-dependent    |
// |               number of cycles and capturing the result of each one.       |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module instr_sequencer #(
    parameter int          MOV_CYCLES = 6,
    parameter int          ALU_CYCLES = 8,
    parameter logic [11:0] IDLE_INSTR = 12'h000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        prog_we,
    input  logic [3:0]  prog_addr,
    input  logic [11:0] prog_data,
    input  logic [3:0]  last_addr,
    input  logic        start,
    input  logic        abort,
    input  logic [3:0]  result_in,
    output logic [11:0] instr_out,
    output logic        busy,
    output logic        result_valid,
    output logic [3:0]  result_out,
    output logic [3:0]  result_pc,
    output logic        done,
    output logic        aborted
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] c_movLast = 4'(MOV_CYCLES - 1);
    localparam logic [3:0] c_aluLast = 4'(ALU_CYCLES - 1);

    state_t      r_state;
    logic [11:0] r_mem [16];
    logic [3:0]  r_pc;
    logic [3:0]  r_cnt;
    logic [3:0]  r_endAddr;
    logic        r_abortPend;

    logic [3:0]  w_nextPc;
    logic [11:0] w_nextInstr;
    logic [11:0] w_firstInstr;

    // Hold counter is loaded with the last cycle index, so it ends at zero.
    function automatic logic [3:0] holdLast(input logic [11:0] instr);
        return instr[11] ? c_movLast : c_aluLast;
    endfunction

    assign w_nextPc     = r_pc + 4'd1;
    assign w_nextInstr  = r_mem[w_nextPc];
    // A write to entry 0 coinciding with start must be seen by the run.
    assign w_firstInstr = (prog_we && (prog_addr == 4'd0)) ? prog_data : r_mem[0];

    always_ff @(posedge clk) begin
        if (prog_we && (r_state == S_IDLE)) begin
            r_mem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= 4'd0;
            r_cnt        <= 4'd0;
            r_endAddr    <= 4'd0;
            r_abortPend  <= 1'b0;
            instr_out    <= IDLE_INSTR;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            result_out   <= 4'd0;
            result_pc    <= 4'd0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            result_valid <= 1'b0;
            done         <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_RUN;
                        busy        <= 1'b1;
                        r_pc        <= 4'd0;
                        instr_out   <= w_firstInstr;
                        r_cnt       <= holdLast(w_firstInstr);
                        r_endAddr   <= last_addr;
                        r_abortPend <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (abort) begin
                        r_abortPend <= 1'b1;
                    end
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        result_out   <= result_in;
                        result_pc    <= r_pc;
                        result_valid <= 1'b1;
                        if ((r_pc == r_endAddr) || r_abortPend || abort) begin
                            r_state   <= S_DONE;
                            instr_out <= IDLE_INSTR;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            aborted   <= r_abortPend | abort;
                        end else begin
                            r_pc      <= w_nextPc;
                            instr_out <= w_nextInstr;
                            r_cnt     <= holdLast(w_nextInstr);
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    aborted <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_sequencer                                           |
// | Description : Scoreboard bench for instr_sequencer with a small behavioural|
// |               stand-in for the processor's ALU and register file.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        prog_we = 1'b0;
    logic [3:0]  prog_addr = 4'd0;
    logic [11:0] prog_data = 12'd0;
    logic [3:0]  last_addr = 4'd0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [3:0]  result_in;
    logic [11:0] instr_out;
    logic        busy;
    logic        result_valid;
    logic [3:0]  result_out;
    logic [3:0]  result_pc;
    logic        done;
    logic        aborted;

    always #5 clk = ~clk;

    instr_sequencer #(
        .MOV_CYCLES(6),
        .ALU_CYCLES(8),
        .IDLE_INSTR(12'h000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .last_addr   (last_addr),
        .start       (start),
        .abort       (abort),
        .result_in   (result_in),
        .instr_out   (instr_out),
        .busy        (busy),
        .result_valid(result_valid),
        .result_out  (result_out),
        .result_pc   (result_pc),
        .done        (done),
        .aborted     (aborted)
    );

    // Processor stand-in: opcode 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR; bit 11 = MOV immediate.
    logic [3:0]  regs [16];
    logic [11:0] progImg [16];
    logic [3:0]  opA;
    logic [3:0]  opB;

    always_comb begin
        opA = regs[instr_out[7:4]];
        opB = regs[instr_out[3:0]];
        result_in = 4'd0;
        if (instr_out[11]) begin
            result_in = instr_out[3:0];
        end else begin
            case (instr_out[10:8])
                3'd0:    result_in = opA + opB;
                3'd1:    result_in = opA - opB;
                3'd2:    result_in = opA & opB;
                3'd3:    result_in = opA | opB;
                3'd4:    result_in = opA ^ opB;
                default: result_in = 4'd0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) regs[i] <= 4'd0;
        end else if (result_valid) begin
            regs[progImg[result_pc][7:4]] <= result_out;
        end
    end

    typedef struct {
        logic [3:0] pc;
        logic [3:0] res;
    } resExp_t;

    resExp_t expRes [$];
    logic    expDone [$];
    int      errors = 0;
    int      checks = 0;
    bit      holdCheckEn = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pushRes(input logic [3:0] pc, input logic [3:0] res);
        resExp_t e;
        e.pc  = pc;
        e.res = res;
        expRes.push_back(e);
    endtask

    // Results of the nine-instruction program, worked out by hand.
    task automatic pushFull();
        pushRes(4'd0, 4'h3);
        pushRes(4'd1, 4'h5);
        pushRes(4'd2, 4'h7);
        pushRes(4'd3, 4'hF);
        pushRes(4'd4, 4'hA);
        pushRes(4'd5, 4'h8);
        pushRes(4'd6, 4'h1);
        pushRes(4'd7, 4'h0);
        pushRes(4'd8, 4'h8);
    endtask

    task automatic monitor();
        resExp_t     e;
        logic        expAb;
        logic [11:0] curInstr = 12'd0;
        int          holdCnt = 0;
        forever begin
            @(negedge clk);
            if (result_valid) begin
                if (expRes.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected result_valid: actual pc=%0h res=%0h expected none", result_pc, result_out);
                end else begin
                    e = expRes.pop_front();
                    chk("result_pc", result_pc, e.pc);
                    chk("result_out", result_out, e.res);
                end
            end
            if (done) begin
                if (expDone.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected done: actual=1 expected=0");
                end else begin
                    expAb = expDone.pop_front();
                    chk("aborted", aborted, expAb);
                end
            end
            if (!holdCheckEn) begin
                holdCnt = 0;
            end else if (busy && holdCnt > 0 && instr_out == curInstr) begin
                holdCnt++;
            end else begin
                if (holdCnt > 0) chk("hold cycles", holdCnt, curInstr[11] ? 6 : 8);
                holdCnt  = busy ? 1 : 0;
                curInstr = instr_out;
            end
        end
    endtask

    task automatic progWrite(input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        progImg[a] = d;
        @(negedge clk);
        prog_we = 1'b0;
    endtask

    task automatic startRun(input logic [3:0] la, input bit wr, input logic [3:0] a, input logic [11:0] d);
        @(negedge clk);
        last_addr = la;
        start     = 1'b1;
        prog_we   = wr;
        prog_addr = a;
        prog_data = d;
        if (wr) progImg[a] = d;
        @(negedge clk);
        start   = 1'b0;
        prog_we = 1'b0;
    endtask

    // mode: 0 none, 1 abort pulse, 2 reset pulse, 3 illegal write + start pulse
    task automatic runAndCount(input int mode, input int injectAt, input logic [11:0] watch,
                               output int cycles, output int hits);
        cycles = 0;
        hits   = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            cycles++;
            if (instr_out == watch) hits++;
            abort     = (mode == 1) && (cycles == injectAt);
            rst       = (mode == 2) && (cycles == injectAt);
            prog_we   = (mode == 3) && (cycles == injectAt);
            start     = (mode == 3) && (cycles == injectAt);
            prog_addr = 4'd3;
            prog_data = 12'h8E1;
            @(negedge clk);
        end
        abort   = 1'b0;
        rst     = 1'b0;
        prog_we = 1'b0;
        start   = 1'b0;
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL run timeout: actual busy=1 expected busy=0 within 200 cycles");
        end
    endtask

    initial begin
        int cyc;
        int hits;
        fork
            monitor();
        join_none

        repeat (2) @(negedge clk);
        chk("reset instr_out", instr_out, 12'h000);
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset result_valid", result_valid, 1'b0);
        chk("reset result_out", result_out, 4'h0);
        chk("reset result_pc", result_pc, 4'h0);
        chk("reset aborted", aborted, 1'b0);
        rst = 1'b0;

        // Single MOV; entry 0 rewritten in the start cycle must be the one executed.
        progWrite(4'd0, 12'h0FF);
        pushRes(4'd0, 4'h3);
        expDone.push_back(1'b0);
        startRun(4'd0, 1'b1, 4'd0, 12'h803);
        runAndCount(0, 0, 12'h803, cyc, hits);
        chk("single run cycles", cyc, 6);
        chk("single 803 held", hits, 6);

        // Abort on the final hold cycle of the final instruction.
        pushRes(4'd0, 4'h3);
        expDone.push_back(1'b1);
        startRun(4'd0, 1'b0, 4'd0, 12'h000);
        runAndCount(1, 6, 12'h803, cyc, hits);
        chk("late abort cycles", cyc, 6);

        progWrite(4'd0, 12'h803);
        progWrite(4'd1, 12'h815);
        progWrite(4'd2, 12'h827);
        progWrite(4'd3, 12'h8EF);
        progWrite(4'd4, 12'h8FA);
        progWrite(4'd5, 12'h010);
        progWrite(4'd6, 12'h112);
        progWrite(4'd7, 12'h21F);
        progWrite(4'd8, 12'h4E2);

        pushFull();
        expDone.push_back(1'b0);
        startRun(4'd8, 1'b0, 4'd0, 12'h000);
        runAndCount(0, 0, 12'h4E2, cyc, hits);
        chk("full run cycles", cyc, 62);
        chk("full 4E2 held", hits, 8);

        // Abort in the third cycle of instruction 1 (run cycle 9).
        pushRes(4'd0, 4'h3);
        pushRes(4'd1, 4'h5);
        expDone.push_back(1'b1);
        startRun(4'd8, 1'b0, 4'd0, 12'h000);
        runAndCount(1, 9, 12'h827, cyc, hits);
        chk("abort run cycles", cyc, 12);
        chk("abort pc2 issued", hits, 0);

        // Write to entry 3 and a second start while running are both ignored.
        pushFull();
        expDone.push_back(1'b0);
        startRun(4'd8, 1'b0, 4'd0, 12'h000);
        runAndCount(3, 20, 12'h8EF, cyc, hits);
        chk("illegal run cycles", cyc, 62);
        chk("illegal 8EF held", hits, 6);

        // Reset in the second cycle of instruction 2 (run cycle 14).
        holdCheckEn = 1'b0;
        pushRes(4'd0, 4'h3);
        pushRes(4'd1, 4'h5);
        startRun(4'd8, 1'b0, 4'd0, 12'h000);
        runAndCount(2, 14, 12'h827, cyc, hits);
        chk("reset run cycles", cyc, 14);
        chk("midrst busy", busy, 1'b0);
        chk("midrst instr_out", instr_out, 12'h000);
        chk("midrst done", done, 1'b0);
        chk("midrst result_valid", result_valid, 1'b0);
        repeat (3) @(negedge clk);
        holdCheckEn = 1'b1;

        // Store survives reset; entry 3 still holds the original MOV.
        pushFull();
        expDone.push_back(1'b0);
        startRun(4'd8, 1'b0, 4'd0, 12'h000);
        runAndCount(0, 0, 12'h8EF, cyc, hits);
        chk("rerun cycles", cyc, 62);
        chk("rerun 8EF held", hits, 6);

        repeat (4) @(negedge clk);
        chk("pending results", expRes.size(), 0);
        chk("pending done", expDone.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
